// File: rtl/c432_resp_capture.sv
// Response capture for the pipelined c432 datapath: aligns the driver's
// vec_valid strobe to the DUT latency, buffers responses in a FIFO and
// compacts them into a MISR signature over a session of num_vec responses.
module c432_resp_capture #(
  parameter int unsigned       DATA_W  = 7,
  parameter int unsigned       LATENCY = 2,
  parameter int unsigned       DEPTH   = 16,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [DATA_W-1:0] SEED    = '0,
  parameter logic [DATA_W-1:0] POLY    = DATA_W'(7'h41)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              vec_valid,
  input  logic [DATA_W-1:0] resp,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  output logic              full,
  output logic              overflow,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  captured,
  output logic              done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LATENCY-1:0]  r_vld;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_captured;
  logic [DATA_W-1:0]   r_sig;
  logic [DATA_W-1:0]   w_sig_nxt;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_cap;
  logic                w_cap_en;
  logic                w_last;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_cap    = r_vld[LATENCY-1];
  // start outranks a coincident capture; that response is discarded
  assign w_cap_en = (r_state == S_CAPTURE) && w_cap && !start;
  assign w_last   = (CNT_W'(r_captured + 1'b1) == r_num);
  assign w_pop    = rd_en && !w_empty && !start;
  // a pop on the same edge frees the slot, so full+pop still accepts the push
  assign w_push   = w_cap_en && (!w_full || w_pop);

  // MISR step: shift, fold the MSB back through the taps, xor the response
  assign w_sig_nxt = {r_sig[DATA_W-2:0], 1'b0}
                   ^ (r_sig[DATA_W-1] ? POLY : '0)
                   ^ resp;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = (num_vec == '0) ? S_DONE : S_CAPTURE;
    end else if (w_cap_en && w_last) begin
      w_state_nxt = S_DONE;
    end
  end

  // Valid delay line; a restart keeps only the vec_valid of the start cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_vld <= '0;
    else if (start) r_vld <= LATENCY'(vec_valid);
    else            r_vld <= LATENCY'({r_vld, vec_valid});
  end

  // Session bookkeeping: target count, captured count, signature, overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num      <= '0;
      r_captured <= '0;
      r_sig      <= SEED;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_num      <= num_vec;
      r_captured <= '0;
      r_sig      <= SEED;
      r_overflow <= 1'b0;
    end else if (w_cap_en) begin
      r_captured <= CNT_W'(r_captured + 1'b1);
      r_sig      <= w_sig_nxt;
      if (!w_push) r_overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= AW'(r_wptr + 1'b1);
      if (w_pop)  r_rptr <= AW'(r_rptr + 1'b1);
      r_count <= (AW+1)'(r_count + (AW+1)'(w_push) - (AW+1)'(w_pop));
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= resp;
  end

  // Registered read port; holds its value when no pop occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rd_data <= '0;
    else if (w_pop) r_rd_data <= r_mem[r_rptr];
  end

  assign rd_data   = r_rd_data;
  assign rd_empty  = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign signature = r_sig;
  assign captured  = r_captured;
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_c432_resp_capture.sv
// Scoreboard bench for c432_resp_capture: stimulus pushes expected FIFO
// contents, a monitor pops and compares on every effective read.
module tb_c432_resp_capture;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_vec;
  logic       vec_valid;
  logic [6:0] resp;
  logic       rd_en;
  logic [6:0] rd_data;
  logic       rd_empty;
  logic       full;
  logic       overflow;
  logic [6:0] signature;
  logic [7:0] captured;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  logic [6:0] exp_q[$];
  logic       pend;
  logic [6:0] e;

  c432_resp_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .vec_valid (vec_valid),
    .resp      (resp),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .full      (full),
    .overflow  (overflow),
    .signature (signature),
    .captured  (captured),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    exp_q.delete();
    start   = 1'b1;
    num_vec = 8'(n);
    tick();
    start   = 1'b0;
  endtask

  // Vector k (k from 0) returns resp k+1, presented LAT cycles after its valid
  task automatic run_vecs(input int n, input logic rd);
    for (int j = 0; j < n + LAT + 3; j++) begin
      vec_valid = (j < n);
      resp      = (j >= LAT && j - LAT < n) ? 7'(j - LAT + 1) : 7'h00;
      rd_en     = rd;
      tick();
    end
    vec_valid = 1'b0;
    rd_en     = 1'b0;
    resp      = 7'h00;
  endtask

  // Monitor: every read that hits a non-empty FIFO must return the next expected entry
  initial begin
    forever begin
      @(negedge clk);
      pend = rd_en && !rd_empty;
      @(posedge clk);
      #2;
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL fifo_pop_unexpected: got 0x%0h expected no data at %0t", rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_pop", int'(rd_data), int'(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vec = 8'd0;
    vec_valid = 1'b0; resp = 7'h00; rd_en = 1'b0;

    // Reset state
    #12;
    chk("rst_signature", signature, 7'h00);
    chk("rst_rd_empty",  rd_empty, 1);
    chk("rst_done",      done, 0);
    chk("rst_captured",  captured, 0);
    chk("rst_full",      full, 0);
    chk("rst_overflow",  overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_signature", signature, 7'h00);
    chk("idle_rd_empty",  rd_empty, 1);
    chk("idle_done",      done, 0);
    chk("idle_captured",  captured, 0);

    // Two-vector session: 0x55 then 0x2A
    do_start(2);
    exp_q.push_back(7'h55);
    exp_q.push_back(7'h2A);
    vec_valid = 1'b1; tick();
    vec_valid = 1'b1; tick();
    vec_valid = 1'b0; resp = 7'h55; tick();
    chk("two_sig1",  signature, 7'h55);
    chk("two_cap1",  captured, 1);
    chk("two_done1", done, 0);
    resp = 7'h2A; tick();
    chk("two_sig2",  signature, 7'h41);
    chk("two_cap2",  captured, 2);
    chk("two_done2", done, 1);
    resp = 7'h00;
    rd_en = 1'b1; tick(); tick();
    rd_en = 1'b0; tick();
    chk("two_empty", rd_empty, 1);

    // Latency alignment: only the response two cycles after the valid counts
    do_start(1);
    exp_q.push_back(7'h03);
    vec_valid = 1'b1; resp = 7'h01; tick();
    vec_valid = 1'b0; resp = 7'h02; tick();
    resp = 7'h03; tick();
    resp = 7'h00;
    chk("lat_captured",  captured, 1);
    chk("lat_signature", signature, 7'h03);
    chk("lat_done",      done, 1);
    rd_en = 1'b1; tick();
    rd_en = 1'b0; tick();

    // Overflow: 20 responses, no reads, only the first 16 survive
    do_start(20);
    run_vecs(20, 1'b0);
    chk("ovf_captured", captured, 20);
    chk("ovf_done",     done, 1);
    chk("ovf_full",     full, 1);
    chk("ovf_overflow", overflow, 1);
    for (int k = 1; k <= 16; k++) exp_q.push_back(7'(k));
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0; tick();
    chk("ovf_drained_empty", rd_empty, 1);
    chk("ovf_drained_full",  full, 0);
    chk("ovf_sticky",        overflow, 1);

    // Same load while popping every cycle: nothing dropped
    do_start(20);
    for (int k = 1; k <= 20; k++) exp_q.push_back(7'(k));
    run_vecs(20, 1'b1);
    chk("pop_overflow", overflow, 0);
    chk("pop_captured", captured, 20);
    chk("pop_done",     done, 1);
    chk("pop_empty",    rd_empty, 1);
    chk("pop_hold",     rd_data, 7'h14);

    // num_vec = 0 finishes at once and ignores later valids
    do_start(0);
    chk("zero_done", done, 1);
    chk("zero_sig",  signature, 7'h00);
    run_vecs(3, 1'b0);
    chk("zero_captured", captured, 0);
    chk("zero_sig_hold", signature, 7'h00);
    chk("zero_empty",    rd_empty, 1);

    // Restart mid-session after 3 captures
    do_start(10);
    for (int j = 0; j < 5; j++) begin
      vec_valid = 1'b1;
      resp      = (j >= LAT) ? 7'(8'h30 + j) : 7'h00;
      tick();
    end
    chk("abort_pre_captured", captured, 3);
    exp_q.delete();
    start = 1'b1; num_vec = 8'd10; vec_valid = 1'b0; resp = 7'h33;
    tick();
    start = 1'b0;
    chk("abort_captured", captured, 0);
    chk("abort_empty",    rd_empty, 1);
    chk("abort_sig",      signature, 7'h00);
    chk("abort_done",     done, 0);
    resp = 7'h44; tick(); tick();
    resp = 7'h00;
    chk("abort_flushed", captured, 0);

    // Reset mid-session aborts immediately
    do_start(10);
    for (int j = 0; j < 4; j++) begin
      vec_valid = 1'b1;
      resp      = (j >= LAT) ? 7'(j + 5) : 7'h00;
      tick();
    end
    chk("rstmid_pre_captured", captured, 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_captured", captured, 0);
    chk("rstmid_sig",      signature, 7'h00);
    chk("rstmid_empty",    rd_empty, 1);
    chk("rstmid_done",     done, 0);
    vec_valid = 1'b0; resp = 7'h00;
    tick();
    rst_n = 1'b1;
    vec_valid = 1'b1; resp = 7'h7F; tick();
    vec_valid = 1'b0; repeat (3) tick();
    chk("rstmid_idle_captured", captured, 0);
    chk("rstmid_idle_empty",    rd_empty, 1);

    repeat (3) tick();
    chk("scoreboard_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/c432_resp_capture.md
# c432_resp_capture

Response-side capture unit for the pipelined c432 benchmark datapath. It is the receiving end of the vector-driving flow: the driver applies one input vector per clock and pulses `vec_valid`, and this block aligns that strobe to the DUT pipeline latency. It then captures each 7-bit response into a readable FIFO and compacts the responses into a MISR signature. A session of `num_vec` responses ends with `done` and a stable signature, so vector runs can be checked in hardware instead of by printing every output.

## Interface
Parameters:
- `DATA_W`, 7, response width (c432 output count)
- `LATENCY`, 2, DUT input-to-output latency in clocks (≥1)
- `DEPTH`, 16, FIFO entries (power of two)
- `CNT_W`, 8, session counter width
- `SEED`, 7'h00, MISR value loaded at session start
- `POLY`, 7'h41, MISR feedback taps

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins a new session
- `num_vec`  in  CNT_W  responses expected; sampled on `start`
- `vec_valid`  in  1  driver applied a vector to the DUT this cycle
- `resp`  in  DATA_W  DUT outputs
- `rd_en`  in  1  pop one FIFO entry
- `rd_data`  out  DATA_W  popped entry, registered
- `rd_empty`  out  1  FIFO empty
- `full`  out  1  FIFO full
- `overflow`  out  1  sticky: a response was dropped
- `signature`  out  DATA_W  MISR value
- `captured`  out  CNT_W  responses captured this session
- `done`  out  1  session complete

## Operation
- Reset (async, `rst_n`=0) sets state IDLE, clears the valid delay line and FIFO pointers, and sets `signature`=SEED. All other outputs reset to 0, except `rd_empty`=1.
- Alignment: a `LATENCY`-stage shift register carries `vec_valid`. `cap` is the stage output, so `resp` is sampled `LATENCY` clocks after the matching `vec_valid`.
- States:
  - IDLE: wait for `start`.
  - CAPTURE: accept `cap` responses.
  - DONE: hold results.
- `start`, from any state: load `num_vec`; clear the delay line, FIFO, `captured` and `overflow`; set `signature`=SEED; go to CAPTURE. If `num_vec`=0, go directly to DONE.
- In CAPTURE, on each edge with `cap`=1:
  - Update the MISR: `sig_next = ((sig<<1) truncated to DATA_W) ^ (sig[DATA_W-1] ? POLY : 0) ^ resp`.
  - Increment `captured`.
  - Push `resp` to the FIFO. If the FIFO is full and no pop occurs that cycle, drop the push and set `overflow`. The MISR and count still update.
  - When `captured` reaches `num_vec` on this edge, go to DONE.
- In IDLE or DONE, `cap` pulses are ignored: no MISR, count or FIFO change.
- FIFO reads are legal in every state. `rd_en` with the FIFO non-empty pops the head into `rd_data`. `rd_en` while empty is ignored and `rd_data` holds its value.
- Simultaneous push and pop when full: both succeed, no overflow. When empty, the push succeeds and the pop is ignored.
- `start` and `cap` in the same cycle: `start` wins and that response is discarded.
- `done` = (state == DONE). `signature` and `captured` hold in DONE until the next `start`.

## Timing
- `vec_valid` at edge t leads to capture of `resp` at edge t+LATENCY.
- `signature`, `captured`, `full`, `rd_empty` and `overflow` all change at the capture edge.
- `done` rises on the same edge as the final capture.
- `rd_data` is valid the cycle after the `rd_en` edge (one-cycle read latency).
- A `start` pulse takes effect on its edge. A `vec_valid` in the start cycle itself is captured `LATENCY` edges later.
- Throughput is one response per clock, sustained.
- Deasserting `rst_n` mid-session aborts immediately. No partial state survives.

## Test plan
- Reset: hold `rst_n`=0 → `signature`=0x00, `rd_empty`=1, `done`=0, `captured`=0. Release, then idle 5 clocks → outputs unchanged.
- Two-vector session: `start` with `num_vec`=2; `vec_valid` on two consecutive cycles with `resp`=0x55 then 0x2A, arriving 2 clocks later → `signature`=0x55 then 0x41, `done`=1 on the second capture, FIFO pops give 0x55 then 0x2A.
- Latency alignment: `vec_valid` once, with `resp` changing every cycle (0x01, 0x02, 0x03) starting at the valid cycle → only 0x03 is captured (LATENCY=2).
- Overflow: `num_vec`=20, 20 back-to-back valids, no reads → 16 entries stored, `full`=1, `overflow`=1, `captured`=20, `done`=1. Repeat while popping every cycle → `overflow`=0.
- `num_vec`=0: `start` → `done`=1 on the next edge and `signature`=SEED. Subsequent valids are ignored.
- Abort: `start` again mid-session after 3 captures → `captured`=0, FIFO empty, `signature`=SEED, state CAPTURE. Assert `rst_n`=0 mid-session → IDLE immediately.
